// File: rtl/time_of_day_counter.sv
// ============================================================================
// Module      : time_of_day_counter
// Description : Free-running 12-hour time-of-day counter with a validated
//               load port. Optional alarm compare when TOD_ALARM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_of_day_counter #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int TICKS_PER_MS = CLK_FREQ_HZ / 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        set_valid,
  input  logic [26:0] set_time,
  input  logic        set_pm,
`ifdef TOD_ALARM_EN
  input  logic        alarm_arm,
  input  logic [16:0] alarm_time,
  input  logic        alarm_pm,
  output logic        alarm_hit,
`endif
  output logic        set_err,
  output logic [26:0] time_out,
  output logic        pm,
  output logic        sec_pulse
);

  localparam int             c_PW = $clog2(TICKS_PER_MS);
  localparam logic [c_PW-1:0] c_TC = c_PW'(TICKS_PER_MS - 1);

  logic [c_PW-1:0] r_presc;
  logic [4:0]      r_hour;
  logic [5:0]      r_min;
  logic [5:0]      r_sec;
  logic [9:0]      r_ms;
  logic            r_pm;
  logic            r_set_err;
  logic            r_sec_pulse;

  logic [4:0]      w_hour_nxt;
  logic [5:0]      w_min_nxt;
  logic [5:0]      w_sec_nxt;
  logic [9:0]      w_ms_nxt;
  logic            w_pm_nxt;
  logic            w_tick;
  logic            w_ms_wrap;
  logic            w_sec_roll;
  logic            w_load_ok;

  assign w_tick     = run && (r_presc == c_TC);
  assign w_ms_wrap  = (r_ms == 10'd999);
  assign w_sec_roll = w_tick && w_ms_wrap;

  assign w_load_ok = set_valid
                     && (set_time[26:22] <= 5'd11)
                     && (set_time[21:16] <= 6'd59)
                     && (set_time[15:10] <= 6'd59)
                     && (set_time[9:0]   <= 10'd999);

  // Carry chain for one ms tick; identity when no tick is due.
  always_comb begin
    w_ms_nxt   = r_ms;
    w_sec_nxt  = r_sec;
    w_min_nxt  = r_min;
    w_hour_nxt = r_hour;
    w_pm_nxt   = r_pm;
    if (w_tick) begin
      if (!w_ms_wrap) begin
        w_ms_nxt = r_ms + 10'd1;
      end else begin
        w_ms_nxt = 10'd0;
        if (r_sec != 6'd59) begin
          w_sec_nxt = r_sec + 6'd1;
        end else begin
          w_sec_nxt = 6'd0;
          if (r_min != 6'd59) begin
            w_min_nxt = r_min + 6'd1;
          end else begin
            w_min_nxt = 6'd0;
            if (r_hour != 5'd11) begin
              w_hour_nxt = r_hour + 5'd1;
            end else begin
              w_hour_nxt = 5'd0;
              w_pm_nxt   = ~r_pm;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_hour      <= 5'd0;
      r_min       <= 6'd0;
      r_sec       <= 6'd0;
      r_ms        <= 10'd0;
      r_pm        <= 1'b0;
      r_set_err   <= 1'b0;
      r_sec_pulse <= 1'b0;
    end else begin
      r_set_err   <= set_valid && !w_load_ok;
      // A valid load swallows any coincident tick, so no pulse either.
      r_sec_pulse <= w_sec_roll && !w_load_ok;
      if (w_load_ok) begin
        r_presc <= '0;
        r_hour  <= set_time[26:22];
        r_min   <= set_time[21:16];
        r_sec   <= set_time[15:10];
        r_ms    <= set_time[9:0];
        r_pm    <= set_pm;
      end else if (run) begin
        r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
        r_hour  <= w_hour_nxt;
        r_min   <= w_min_nxt;
        r_sec   <= w_sec_nxt;
        r_ms    <= w_ms_nxt;
        r_pm    <= w_pm_nxt;
      end
    end
  end

`ifdef TOD_ALARM_EN
  logic r_alarm_hit;

  // Fires only on a counted second change into the alarm time, never on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alarm_hit <= 1'b0;
    end else begin
      r_alarm_hit <= alarm_arm && w_sec_roll && !w_load_ok
                     && ({w_hour_nxt, w_min_nxt, w_sec_nxt} == alarm_time)
                     && (w_pm_nxt == alarm_pm);
    end
  end

  assign alarm_hit = r_alarm_hit;
`endif

  assign time_out  = {r_hour, r_min, r_sec, r_ms};
  assign pm        = r_pm;
  assign set_err   = r_set_err;
  assign sec_pulse = r_sec_pulse;

endmodule

`default_nettype wire

// File: tb/tb_time_of_day_counter.sv
// ============================================================================
// Module      : tb_time_of_day_counter
// Description : Scoreboard bench for time_of_day_counter (TICKS_PER_MS = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_of_day_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        set_valid;
  logic [26:0] set_time;
  logic        set_pm;
  logic        set_err;
  logic [26:0] time_out;
  logic        pm;
  logic        sec_pulse;
`ifdef TOD_ALARM_EN
  logic        alarm_arm;
  logic [16:0] alarm_time;
  logic        alarm_pm;
  logic        alarm_hit;
`endif

  always #5 clk = ~clk;

  time_of_day_counter #(
    .CLK_FREQ_HZ (4000),
    .TICKS_PER_MS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .set_valid (set_valid),
    .set_time  (set_time),
    .set_pm    (set_pm),
`ifdef TOD_ALARM_EN
    .alarm_arm (alarm_arm),
    .alarm_time(alarm_time),
    .alarm_pm  (alarm_pm),
    .alarm_hit (alarm_hit),
`endif
    .set_err   (set_err),
    .time_out  (time_out),
    .pm        (pm),
    .sec_pulse (sec_pulse)
  );

  typedef struct packed {
    int          cyc;
    logic [95:0] name;
    logic [26:0] t;
    logic        pm;
    logic        sp;
    logic        se;
    logic        ah;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [26:0] tw(input int h, input int m, input int s, input int ms);
    return {h[4:0], m[5:0], s[5:0], ms[9:0]};
  endfunction

  task automatic push(input logic [95:0] nm, input int d, input logic [26:0] t,
                      input logic p, input logic sp, input logic se, input logic ah);
    exp_t e;
    e.cyc  = cyc + d;
    e.name = nm;
    e.t    = t;
    e.pm   = p;
    e.sp   = sp;
    e.se   = se;
    e.ah   = ah;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cycle either matches a queued expectation or must be pulse-free.
  exp_t mon_e;
  bit   mon_got;
  logic mon_ah;
  always begin
    @(posedge clk);
    #1;
    cyc++;
`ifdef TOD_ALARM_EN
    mon_ah = alarm_hit;
`else
    mon_ah = 1'b0;
`endif
    mon_got = 1'b0;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e   = q.pop_front();
      mon_got = 1'b1;
      checks++;
      if (mon_e.cyc != cyc || time_out !== mon_e.t || pm !== mon_e.pm ||
          sec_pulse !== mon_e.sp || set_err !== mon_e.se || mon_ah !== mon_e.ah) begin
        errors++;
        $display("FAIL %s @cyc %0d (due %0d): got time=%h pm=%b sec_pulse=%b set_err=%b alarm=%b, want time=%h pm=%b sec_pulse=%b set_err=%b alarm=%b",
                 mon_e.name, cyc, mon_e.cyc, time_out, pm, sec_pulse, set_err, mon_ah,
                 mon_e.t, mon_e.pm, mon_e.sp, mon_e.se, mon_e.ah);
      end
    end
    if (!mon_got) begin
      checks++;
      if (sec_pulse !== 1'b0 || set_err !== 1'b0 || mon_ah !== 1'b0) begin
        errors++;
        $display("FAIL unexpected_pulse @cyc %0d: got sec_pulse=%b set_err=%b alarm=%b, want all 0",
                 cyc, sec_pulse, set_err, mon_ah);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    run       = 1'b0;
    set_valid = 1'b0;
    set_time  = '0;
    set_pm    = 1'b0;
`ifdef TOD_ALARM_EN
    alarm_arm  = 1'b0;
    alarm_time = '0;
    alarm_pm   = 1'b0;
`endif
    step(1);
    push("reset", 1, 27'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);

    // First ms tick lands on the 4th clock after run is raised.
    rst = 1'b0;
    run = 1'b1;
    push("run_pre", 3, 27'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("run_ms1", 4, 27'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4);
    run = 1'b0;

    // Full wrap 11:59:59.999 AM -> 00:00:00.000 PM.
    set_valid = 1'b1;
    set_time  = tw(11, 59, 59, 999);
    set_pm    = 1'b0;
    push("wrap_load", 1, tw(11, 59, 59, 999), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    set_valid = 1'b0;
    run       = 1'b1;
    push("wrap_pre", 3, tw(11, 59, 59, 999), 1'b0, 1'b0, 1'b0, 1'b0);
    push("wrap_tick", 4, 27'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    push("wrap_after", 5, 27'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5);
    run = 1'b0;

    // Freeze for 20 clocks, then resume; load also clears the prescaler.
    set_valid = 1'b1;
    set_time  = tw(0, 0, 58, 999);
    set_pm    = 1'b0;
    push("frz_load", 1, tw(0, 0, 58, 999), 1'b0, 1'b0, 1'b0, 1'b0);
    push("frz_hold", 21, tw(0, 0, 58, 999), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    set_valid = 1'b0;
    step(20);
    run = 1'b1;
    push("frz_pre", 3, tw(0, 0, 58, 999), 1'b0, 1'b0, 1'b0, 1'b0);
    push("frz_sec", 4, tw(0, 0, 59, 0), 1'b0, 1'b1, 1'b0, 1'b0);
    push("frz_after", 5, tw(0, 0, 59, 0), 1'b0, 1'b0, 1'b0, 1'b0);
    step(5);
    run = 1'b0;

    // Back-to-back rejected loads; time and pm must not move.
    set_valid = 1'b1;
    set_pm    = 1'b1;
    set_time  = tw(12, 0, 0, 0);
    push("bad_hour", 1, tw(0, 0, 59, 0), 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    set_time = tw(0, 60, 0, 0);
    push("bad_min", 1, tw(0, 0, 59, 0), 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    set_time = tw(0, 0, 0, 1000);
    push("bad_ms", 1, tw(0, 0, 59, 0), 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    set_valid = 1'b0;
    push("bad_idle", 1, tw(0, 0, 59, 0), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);

    // Load on the terminal-count cycle discards that tick.
    set_valid = 1'b1;
    set_time  = tw(1, 2, 3, 4);
    set_pm    = 1'b0;
    run       = 1'b1;
    push("tc_x", 1, tw(1, 2, 3, 4), 1'b0, 1'b0, 1'b0, 1'b0);
    push("tc_x_hold", 4, tw(1, 2, 3, 4), 1'b0, 1'b0, 1'b0, 1'b0);
    push("tc_y", 5, tw(2, 3, 4, 500), 1'b1, 1'b0, 1'b0, 1'b0);
    push("tc_y_hold", 8, tw(2, 3, 4, 500), 1'b1, 1'b0, 1'b0, 1'b0);
    push("tc_y_tick", 9, tw(2, 3, 4, 501), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    set_valid = 1'b0;
    step(3);
    set_valid = 1'b1;
    set_time  = tw(2, 3, 4, 500);
    set_pm    = 1'b1;
    step(1);
    set_valid = 1'b0;
    step(4);
    run = 1'b0;

`ifdef TOD_ALARM_EN
    rst = 1'b1;
    push("al_reset", 1, 27'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    rst        = 1'b0;
    run        = 1'b1;
    alarm_arm  = 1'b1;
    alarm_time = {5'd0, 6'd0, 6'd1};
    alarm_pm   = 1'b0;
    push("al_pre", 3999, tw(0, 0, 0, 999), 1'b0, 1'b0, 1'b0, 1'b0);
    push("al_hit", 4000, tw(0, 0, 1, 0), 1'b0, 1'b1, 1'b0, 1'b1);
    push("al_after", 4001, tw(0, 0, 1, 0), 1'b0, 1'b0, 1'b0, 1'b0);
    step(4001);
    run = 1'b0;
`endif

    for (int i = 0; i < 50 && q.size() > 0; i++) step(1);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d expectations still queued, want 0", q.size());
    end
    step(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
